// File: rtl/rv_lsu_pipelined.sv
// Pipelined load-store unit: grant-based bus issue, in-order response FIFO,
// lane alignment, load extension, misalignment detection and kill handling.
// Ports: clk_i/arstn_i; lsu_* pipeline side (req, we, size, addr, data, kill,
// ready, stall, misaligned, rvalid, data_o, busy); data_* bus side
// (req, gnt, we, be, addr, wdata, rvalid, rdata).
module rv_lsu_pipelined #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  input  logic              lsu_kill_i,
  output logic              lsu_ready_o,
  output logic              lsu_stall_o,
  output logic              lsu_misaligned_o,
  output logic              lsu_rvalid_o,
  output logic [XLEN-1:0]   lsu_data_o,
  output logic              lsu_busy_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i
);

  localparam int BW = XLEN / 8;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic       we;
    logic       uns;
    logic [1:0] sz;
    logic [1:0] off;
    logic       killed;
  } ent_t;

  ent_t          fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]      sz;
  logic [1:0]      off;
  logic            uns;
  logic            misal;
  logic            accept;
  logic            pop;
  logic            head_live;
  ent_t            head;
  logic [XLEN-1:0] lane;

  assign sz  = lsu_size_i[1:0];
  assign uns = lsu_size_i[2];
  assign off = lsu_addr_i[1:0];

  assign misal = (sz == 2'b11)
               | ((sz == 2'b01) & off[0])
               | ((sz == 2'b10) & (off != 2'b00));

  assign data_req_o = lsu_req_i & ~misal & ~lsu_kill_i
                    & (cnt_q < MAXC);
  assign accept     = data_req_o & data_gnt_i;

  assign lsu_misaligned_o = lsu_req_i & misal;
  assign lsu_ready_o      = accept | lsu_misaligned_o;
  assign lsu_busy_o       = (cnt_q != '0);

  assign head = fifo_q[rptr_q];
  assign pop  = data_rvalid_i & (cnt_q != '0);

  assign head_live    = (cnt_q != '0) & ~head.we & ~head.killed;
  assign lsu_rvalid_o = pop & ~head.we & ~head.killed;

  // A kill flushes the pipeline, so nothing is left to hold for.
  assign lsu_stall_o = ~lsu_kill_i
                     & ((lsu_req_i & ~lsu_ready_o)
                     | (head_live & ~data_rvalid_i));

  // Bus payload is only driven while a request is presented.
  always_comb begin
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_we_o   = lsu_we_i;
      data_addr_o = {lsu_addr_i[XLEN-1:2], 2'b00};
      unique case (1'b1)
        sz == 2'b00: begin
          data_be_o    = BW'(1) << off;
          data_wdata_o = {BW{lsu_data_i[7:0]}};
        end
        sz == 2'b01: begin
          data_be_o    = BW'(3) << off;
          data_wdata_o = {(XLEN/16){lsu_data_i[15:0]}};
        end
        default: begin
          data_be_o    = BW'(15);
          data_wdata_o = lsu_data_i;
        end
      endcase
    end
  end

  assign lane = data_rdata_i >> {head.off, 3'b000};

  always_comb begin
    lsu_data_o = '0;
    if (lsu_rvalid_o) begin
      unique case (1'b1)
        head.sz == 2'b00:
          lsu_data_o = {{(XLEN-8){~head.uns & lane[7]}}, lane[7:0]};
        head.sz == 2'b01:
          lsu_data_o = {{(XLEN-16){~head.uns & lane[15]}}, lane[15:0]};
        default:
          lsu_data_o = lane;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (lsu_kill_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i].killed <= 1'b1;
      end
      if (accept) begin
        fifo_q[wptr_q] <= '{we: lsu_we_i, uns: uns, sz: sz,
                            off: off, killed: 1'b0};
        wptr_q <= (wptr_q == LASTP) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LASTP) ? '0 : rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(accept) - CW'(pop);
    end
  end

  a_no_orphan_rvalid : assert property (
    @(posedge clk_i) disable iff (!arstn_i)
    !(data_rvalid_i && (cnt_q == '0)));

endmodule

// File: tb/tb_rv_lsu_pipelined.sv
// Directed testbench for rv_lsu_pipelined.
// Inputs change 1 ns after posedge; outputs are checked 3 ns after posedge.
module tb_rv_lsu_pipelined;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_kill_i;
  logic        lsu_ready_o;
  logic        lsu_stall_o;
  logic        lsu_misaligned_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_data_o;
  logic        lsu_busy_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  rv_lsu_pipelined #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i),
    .lsu_data_i(lsu_data_i), .lsu_kill_i(lsu_kill_i),
    .lsu_ready_o(lsu_ready_o), .lsu_stall_o(lsu_stall_o),
    .lsu_misaligned_o(lsu_misaligned_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_data_o(lsu_data_o),
    .lsu_busy_o(lsu_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    lsu_req_i     = 1'b0;
    lsu_we_i      = 1'b0;
    lsu_size_i    = 3'b000;
    lsu_addr_i    = '0;
    lsu_data_i    = '0;
    lsu_kill_i    = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] s);
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = s;
    lsu_addr_i = a;
    data_gnt_i = 1'b1;
  endtask

  task automatic test_reset();
    arstn_i = 1'b0;
    idle();
    tick();
    tick();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%h exp=0", lsu_busy_o); end
    n_cmp++; if ({lsu_ready_o, lsu_stall_o, lsu_rvalid_o, lsu_misaligned_o} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {lsu_ready_o, lsu_stall_o, lsu_rvalid_o, lsu_misaligned_o}); end
    n_cmp++; if ({data_req_o, data_we_o, data_be_o, lsu_data_o} !== 38'b0) begin n_err++; $display("FAIL rst_bus got=%h exp=0", {data_req_o, data_we_o, data_be_o, lsu_data_o}); end
    tick();
    arstn_i = 1'b1;
  endtask

  task automatic test_word_load();
    tick();
    load(32'h100, 3'b010);
    #2;
    n_cmp++; if (data_req_o !== 1'b1) begin n_err++; $display("FAIL wl_req got=%h exp=1", data_req_o); end
    n_cmp++; if (data_be_o !== 4'b1111) begin n_err++; $display("FAIL wl_be got=%b exp=1111", data_be_o); end
    n_cmp++; if (data_addr_o !== 32'h100) begin n_err++; $display("FAIL wl_addr got=%h exp=00000100", data_addr_o); end
    n_cmp++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL wl_ready got=%h exp=1", lsu_ready_o); end
    n_cmp++; if (lsu_stall_o !== 1'b0) begin n_err++; $display("FAIL wl_stall0 got=%h exp=0", lsu_stall_o); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b1) begin n_err++; $display("FAIL wl_busy got=%h exp=1", lsu_busy_o); end
    n_cmp++; if (lsu_stall_o !== 1'b1) begin n_err++; $display("FAIL wl_stall_wait got=%h exp=1", lsu_stall_o); end
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hDEADBEEF;
    #2;
    n_cmp++; if (lsu_rvalid_o !== 1'b1) begin n_err++; $display("FAIL wl_rvalid got=%h exp=1", lsu_rvalid_o); end
    n_cmp++; if (lsu_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL wl_data got=%h exp=deadbeef", lsu_data_o); end
    n_cmp++; if (lsu_stall_o !== 1'b0) begin n_err++; $display("FAIL wl_stall_resp got=%h exp=0", lsu_stall_o); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL wl_busy_end got=%h exp=0", lsu_busy_o); end
    n_cmp++; if (lsu_data_o !== 32'h0) begin n_err++; $display("FAIL wl_data_idle got=%h exp=0", lsu_data_o); end
  endtask

  task automatic test_extend();
    logic [31:0] addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    logic [2:0]  size [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] rd   [5] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF,
                              32'h1234F00D, 32'h00007F00};
    logic [31:0] exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                              32'h0000F00D, 32'h0000007F};
    logic [3:0]  be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      tick();
      load(addr[i], size[i]);
      #2;
      n_cmp++; if (data_be_o !== be[i]) begin n_err++; $display("FAIL ext_be[%0d] got=%b exp=%b", i, data_be_o, be[i]); end
      tick();
      idle();
      data_rvalid_i = 1'b1;
      data_rdata_i  = rd[i];
      #2;
      n_cmp++; if (lsu_data_o !== exp[i]) begin n_err++; $display("FAIL ext_data[%0d] got=%h exp=%h", i, lsu_data_o, exp[i]); end
      tick();
      idle();
    end
  endtask

  task automatic test_store();
    tick();
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b1;
    lsu_size_i = 3'b000;
    lsu_addr_i = 32'h101;
    lsu_data_i = 32'h000000AB;
    data_gnt_i = 1'b1;
    #2;
    n_cmp++; if (data_be_o !== 4'b0010) begin n_err++; $display("FAIL st_be got=%b exp=0010", data_be_o); end
    n_cmp++; if (data_wdata_o !== 32'hABABABAB) begin n_err++; $display("FAIL st_wdata got=%h exp=abababab", data_wdata_o); end
    n_cmp++; if (data_we_o !== 1'b1) begin n_err++; $display("FAIL st_we got=%h exp=1", data_we_o); end
    n_cmp++; if (data_addr_o !== 32'h100) begin n_err++; $display("FAIL st_addr got=%h exp=00000100", data_addr_o); end
    tick();
    lsu_size_i = 3'b001;
    lsu_addr_i = 32'h102;
    lsu_data_i = 32'hFFFF1234;
    #2;
    n_cmp++; if ({data_be_o, data_wdata_o} !== {4'b1100, 32'h12341234}) begin n_err++; $display("FAIL st_half got=%h exp=c12341234", {data_be_o, data_wdata_o}); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_stall_o !== 1'b0) begin n_err++; $display("FAIL st_stall got=%h exp=0", lsu_stall_o); end
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h55555555;
    #2;
    n_cmp++; if (lsu_rvalid_o !== 1'b0) begin n_err++; $display("FAIL st_rvalid1 got=%h exp=0", lsu_rvalid_o); end
    tick();
    #2;
    n_cmp++; if ({lsu_rvalid_o, lsu_data_o} !== 33'b0) begin n_err++; $display("FAIL st_rvalid2 got=%h exp=0", {lsu_rvalid_o, lsu_data_o}); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL st_busy got=%h exp=0", lsu_busy_o); end
  endtask

  task automatic test_back_to_back();
    tick();
    load(32'h200, 3'b010);
    tick();
    load(32'h204, 3'b010);
    tick();
    load(32'h208, 3'b010);
    #2;
    n_cmp++; if ({data_req_o, lsu_ready_o} !== 2'b00) begin n_err++; $display("FAIL b2b_hold got=%b exp=00", {data_req_o, lsu_ready_o}); end
    n_cmp++; if (lsu_stall_o !== 1'b1) begin n_err++; $display("FAIL b2b_stall got=%h exp=1", lsu_stall_o); end
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hA0A0A0A0;
    #2;
    n_cmp++; if (data_req_o !== 1'b0) begin n_err++; $display("FAIL b2b_hold2 got=%h exp=0", data_req_o); end
    n_cmp++; if ({lsu_rvalid_o, lsu_data_o} !== {1'b1, 32'hA0A0A0A0}) begin n_err++; $display("FAIL b2b_r0 got=%h exp=1a0a0a0a0", {lsu_rvalid_o, lsu_data_o}); end
    tick();
    data_rvalid_i = 1'b0;
    #2;
    n_cmp++; if ({data_req_o, lsu_ready_o} !== 2'b11) begin n_err++; $display("FAIL b2b_issue3 got=%b exp=11", {data_req_o, lsu_ready_o}); end
    n_cmp++; if (data_addr_o !== 32'h208) begin n_err++; $display("FAIL b2b_addr3 got=%h exp=00000208", data_addr_o); end
    tick();
    idle();
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hB1B1B1B1;
    #2;
    n_cmp++; if ({lsu_rvalid_o, lsu_data_o} !== {1'b1, 32'hB1B1B1B1}) begin n_err++; $display("FAIL b2b_r1 got=%h exp=1b1b1b1b1", {lsu_rvalid_o, lsu_data_o}); end
    tick();
    data_rdata_i = 32'hC2C2C2C2;
    #2;
    n_cmp++; if ({lsu_rvalid_o, lsu_data_o} !== {1'b1, 32'hC2C2C2C2}) begin n_err++; $display("FAIL b2b_r2 got=%h exp=1c2c2c2c2", {lsu_rvalid_o, lsu_data_o}); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_busy got=%h exp=0", lsu_busy_o); end
  endtask

  task automatic test_kill();
    tick();
    load(32'h300, 3'b010);
    tick();
    load(32'h304, 3'b010);
    tick();
    load(32'h308, 3'b010);
    lsu_kill_i = 1'b1;
    #2;
    n_cmp++; if ({data_req_o, lsu_ready_o, lsu_stall_o} !== 3'b000) begin n_err++; $display("FAIL kill_drop got=%b exp=000", {data_req_o, lsu_ready_o, lsu_stall_o}); end
    tick();
    idle();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h11111111;
    #2;
    n_cmp++; if ({lsu_rvalid_o, lsu_stall_o} !== 2'b00) begin n_err++; $display("FAIL kill_r0 got=%b exp=00", {lsu_rvalid_o, lsu_stall_o}); end
    n_cmp++; if (lsu_busy_o !== 1'b1) begin n_err++; $display("FAIL kill_busy got=%h exp=1", lsu_busy_o); end
    tick();
    #2;
    n_cmp++; if (lsu_rvalid_o !== 1'b0) begin n_err++; $display("FAIL kill_r1 got=%h exp=0", lsu_rvalid_o); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL kill_busy_end got=%h exp=0", lsu_busy_o); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr [4] = '{32'h102, 32'h100, 32'h101, 32'h103};
    logic [2:0]  size [4] = '{3'b010, 3'b011, 3'b001, 3'b110};
    for (int i = 0; i < 4; i++) begin
      tick();
      load(addr[i], size[i]);
      #2;
      n_cmp++; if ({lsu_misaligned_o, data_req_o, lsu_ready_o, lsu_stall_o} !== 4'b1010) begin n_err++; $display("FAIL mis[%0d] got=%b exp=1010", i, {lsu_misaligned_o, data_req_o, lsu_ready_o, lsu_stall_o}); end
    end
    tick();
    load(32'h102, 3'b001);
    data_gnt_i = 1'b0;
    #2;
    n_cmp++; if ({lsu_misaligned_o, data_req_o, lsu_ready_o, lsu_stall_o} !== 4'b0101) begin n_err++; $display("FAIL mis_ok_nognt got=%b exp=0101", {lsu_misaligned_o, data_req_o, lsu_ready_o, lsu_stall_o}); end
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b0) begin n_err++; $display("FAIL mis_busy got=%h exp=0", lsu_busy_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    load(32'h400, 3'b010);
    tick();
    idle();
    #2;
    n_cmp++; if (lsu_busy_o !== 1'b1) begin n_err++; $display("FAIL rm_busy got=%h exp=1", lsu_busy_o); end
    arstn_i = 1'b0;
    #1;
    n_cmp++; if ({lsu_busy_o, lsu_stall_o} !== 2'b00) begin n_err++; $display("FAIL rm_clear got=%b exp=00", {lsu_busy_o, lsu_stall_o}); end
    tick();
    arstn_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_extend();
    test_store();
    test_back_to_back();
    test_kill();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_lsu_pipelined.md
Name: rv_lsu_pipelined

Overview:
Pipelined load-store unit. It replaces the single-outstanding LSU used by the memory stage. Requests are issued on a grant-based data-memory interface, and up to MAX_OUTSTANDING transactions may be in flight, tracked by an internal response FIFO. It performs byte-enable and write-data alignment, load sign/zero extension, misalignment detection and kill handling; responses return in order.

Parameters:
XLEN, 32, data/address width; multiple of 32; only 32 is verified.
MAX_OUTSTANDING, 2, maximum issued-but-unanswered transactions; power of two, 1..8.

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
lsu_req_i  in  1  valid memory request from pipeline
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  {uns, sz[1:0]}; sz 00 byte, 01 half, 10 word, 11 illegal; uns = zero-extend load
lsu_addr_i  in  XLEN  byte address
lsu_data_i  in  XLEN  store data, right-justified
lsu_kill_i  in  1  flush: cancel current request and all in-flight loads
lsu_ready_o  out  1  request accepted this cycle
lsu_stall_o  out  1  pipeline must hold
lsu_misaligned_o  out  1  misaligned or illegal-size request; no bus access
lsu_rvalid_o  out  1  load result valid (one pulse per unkilled load)
lsu_data_o  out  XLEN  formatted load result
lsu_busy_o  out  1  any transaction in flight
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_we_o  out  1  bus write enable
data_be_o  out  XLEN/8  byte enables
data_addr_o  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
data_wdata_o  out  XLEN  lane-replicated store data
data_rvalid_i  in  1  bus response valid, in order, at least 1 cycle after grant
data_rdata_i  in  XLEN  bus read data

Behaviour:
- Reset: all outputs 0; FIFO empty; outstanding count 0.
- Alignment: misaligned if half with addr[0]=1, word with addr[1:0]!=0, or sz=11. Misaligned requests drive lsu_misaligned_o combinationally and lsu_ready_o=1. They never assert data_req_o and never produce rvalid.
- Issue: data_req_o = lsu_req_i & ~misaligned & ~kill & (count < MAX_OUTSTANDING). Bus outputs are combinational from the request inputs. data_req_o and its payload hold stable until data_gnt_i.
- Acceptance: the request is accepted on the cycle data_req_o & data_gnt_i. lsu_ready_o equals that acceptance, OR the misaligned case.
- Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111. wdata: byte replicated x4, half replicated x2, word as-is.
- FIFO: every accepted transaction pushes {we, uns, sz, a[1:0], killed=0}. Stores push too and pop on their rvalid, with no lsu_rvalid_o.
- Response: on data_rvalid_i, pop the head entry. If it is a load and not killed, lsu_rvalid_o=1 in the same cycle (combinational). lsu_data_o = selected lane, sign-extended (uns=0) or zero-extended (uns=1). When lsu_rvalid_o=0, lsu_data_o is 0.
- Count: +1 on accept, -1 on rvalid; both in the same cycle leaves it unchanged. A push while full is impossible (req gated). data_rvalid_i with an empty FIFO is a protocol error: it is ignored and fires an assertion.
- Stall: lsu_stall_o = (lsu_req_i & ~lsu_ready_o) | (head is an unkilled load, no rvalid this cycle).
- Kill: the current un-granted request is dropped. All FIFO entries get killed=1; their responses are popped silently. lsu_stall_o is forced 0 that cycle, and the count is not cleared.
- Reset mid-transaction: state is cleared immediately. The bus agent is also reset by the same reset.

Test Plan:
- Word load addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> data_be_o=1111, lsu_rvalid_o with lsu_data_o=0xDEADBEEF, stall 1 cycle.
- Byte loads at addr 0x103, rdata 0x80FF_FF_FF: signed gives 0xFFFFFF80, unsigned gives 0x00000080. Half load at 0x102, signed -> 0xFFFF80FF.
- Byte store 0xAB at addr 0x101 -> data_be_o=0010, data_wdata_o=0xABABABAB, data_we_o=1, no lsu_rvalid_o.
- MAX_OUTSTANDING=2, three back-to-back loads, rvalid delayed 3 cycles -> third request held (data_req_o=0, lsu_ready_o=0) until first rvalid. Results are returned in order.
- Two loads granted, kill asserted before responses -> both rvalids consumed, lsu_rvalid_o stays 0, lsu_busy_o drops after the second.
- Word load at 0x102 and size 11 -> lsu_misaligned_o=1, data_req_o=0, FIFO unchanged.
